gcd_param: RTL
==============

GCD_PARAM -- requirements
Module: gcd_param

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width (legal range: 2 or more).
REQ-002 Parameter CNT_W, default 16, width of the cycle counter output.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-005 io_in_valid  input  1  operand pair offered.
REQ-006 io_in_ready  output  1  high only in IDLE.
REQ-007 io_in_a  input  WIDTH  operand A.
REQ-008 io_in_b  input  WIDTH  operand B.
REQ-009 io_in_mode  input  1  0 = subtractive Euclid; 1 = binary (Stein).
REQ-010 io_abort  input  1  cancel the computation in progress.
REQ-011 io_out_valid  output  1  result available (DONE state).
REQ-012 io_out_ready  input  1  consumer accepts the result.
REQ-013 io_out_gcd  output  WIDTH  gcd(A,B), with gcd(0,0)=0.
REQ-014 io_out_cycles  output  CNT_W  RUN cycles spent, saturating.
REQ-015 io_busy  output  1  high in RUN or DONE.

Function
REQ-016 The block SHALL implement states IDLE, RUN and DONE; only one operation is in flight at a time.
REQ-017 IDLE: on io_in_valid=1 at a rising edge, the block SHALL latch x=A, y=B, mode and k=0, clear the counter and enter RUN; io_in_valid is ignored in RUN and DONE.
REQ-018 Every RUN cycle SHALL increment the counter, saturating at 2^CNT_W-1; the increment includes the terminating cycle.
REQ-019 Termination check in every RUN cycle, both modes: if x==0 or y==0, then result=(x|y)<<k, enter DONE, no x/y update.
REQ-020 Mode 0 update, applied when not terminating:
- x>y: x<=x-y
- otherwise: y<=y-x
- k stays 0.
REQ-021 Mode 1 update, applied when not terminating, in priority order:
- x and y both even: x>>=1, y>>=1, k++
- x even: x>>=1
- y even: y>>=1
- x>=y: x<=(x-y)>>1
- otherwise: y<=(y-x)>>1.
REQ-022 All arithmetic SHALL be unsigned at WIDTH bits, and k SHALL be clog2(WIDTH)+1 bits; no intermediate value exceeds WIDTH bits.
REQ-023 DONE: io_out_valid=1, and io_out_gcd and io_out_cycles SHALL stay stable until io_out_ready=1 at an edge, which returns the block to IDLE.
REQ-024 The earliest new acceptance SHALL be the cycle after the result handshake, because io_in_ready is low in DONE.
REQ-025 io_abort=1 in RUN SHALL return the block to IDLE at the next edge with no output.
REQ-026 io_abort and termination in the same cycle: abort wins and no result is produced.
REQ-027 io_abort SHALL be ignored in IDLE and DONE.
REQ-028 Latency SHALL be 1 cycle from acceptance to the first RUN cycle, plus N RUN cycles, where N equals io_out_cycles when the counter is unsaturated.

Reset
REQ-029 While reset is low the block SHALL hold IDLE with x, y, k, counter and result all cleared to 0.
REQ-030 Output reset values: io_in_ready=1; io_out_valid=0; io_out_gcd=0; io_out_cycles=0; io_busy=0.
REQ-031 Reset asserted in RUN or DONE SHALL discard the operation; after reset deasserts, the first rising edge may accept a new operand pair.

Verification
REQ-032 mode0, A=6, B=4 -> io_out_gcd=2, io_out_cycles=4; path (6,4)->(2,4)->(2,2)->(2,0)->terminate.
REQ-033 mode1, A=12, B=8 -> io_out_gcd=4, io_out_cycles=6, final k=2.
REQ-034 A=0, B=0 in each mode -> io_out_gcd=0, io_out_cycles=1; A=0, B=25 in mode0 -> io_out_gcd=25, io_out_cycles=1.
REQ-035 mode0, A=76, B=25, io_out_ready held low 5 cycles after io_out_valid rises -> io_out_gcd=1, outputs stable and io_in_ready=0 throughout; io_in_valid pulses during RUN are ignored.
REQ-036 WIDTH=16, CNT_W=8, mode0, A=0xFFFF, B=1 -> io_out_gcd=1, io_out_cycles=255 (saturated); the same operands in mode1 -> io_out_gcd=1 with an unsaturated count.
REQ-037 Cancellation checks:
- io_abort in the 3rd RUN cycle of A=6, B=4 -> IDLE next cycle, no io_out_valid pulse.
- A following A=9, B=6 -> io_out_gcd=3.
- Reset low mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/gcd_param_if.sv
// gcd_param_if -- operand/result handshake bundle for gcd_param.
//   slave  : seen by the GCD engine (takes operands, produces the result)
//   master : seen by the producer/consumer driving the engine
// Signals:
//   io_in_valid/io_in_ready   operand pair handshake (io_in_a, io_in_b, io_in_mode)
//   io_abort                  cancel the computation in progress
//   io_out_valid/io_out_ready result handshake (io_out_gcd, io_out_cycles)
//   io_busy                   engine is computing or holding a result
interface gcd_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic             io_in_mode;
  logic             io_abort;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_gcd;
  logic [CNT_W-1:0] io_out_cycles;
  logic             io_busy;

  modport slave (
    input  io_in_valid, io_in_a, io_in_b, io_in_mode, io_abort, io_out_ready,
    output io_in_ready, io_out_valid, io_out_gcd, io_out_cycles, io_busy
  );

  modport master (
    output io_in_valid, io_in_a, io_in_b, io_in_mode, io_abort, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_gcd, io_out_cycles, io_busy
  );
endinterface

// File: rtl/gcd_param.sv
// gcd_param -- multi-cycle GCD engine, subtractive Euclid (mode 0) or
// binary Stein (mode 1), one operation in flight at a time.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   io     gcd_param_if.slave: operand handshake, abort, result handshake,
//          saturating RUN-cycle count and busy flag
// Flow: IDLE accepts an operand pair, RUN iterates one step per cycle
// (counting every RUN cycle, including the terminating one), DONE holds the
// result until the consumer takes it. Abort in RUN drops back to IDLE.
module gcd_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  gcd_param_if.slave  io
);
  // Shift count for common factors of two removed in binary mode.
  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] diff_xy;
  logic [WIDTH-1:0] diff_yx;

  // NOTE: every register, datapath included, is cleared by reset so the
  // outputs show defined values while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values computed for this edge, independent of statement order.
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign diff_xy = x_q - y_q;
  assign diff_yx = y_q - x_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (io.io_in_valid) begin
          x_d     = io.io_in_a;
          y_d     = io.io_in_b;
          mode_d  = io.io_in_mode;
          k_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (io.io_abort) begin
          // Abort beats termination: nothing is published.
          state_d = IDLE;
        end else if (x_q == '0 || y_q == '0) begin
          // The nonzero operand (or zero) is the odd part; restore 2^k.
          res_d   = (x_q | y_q) << k_q;
          state_d = DONE;
        end else if (!mode_q) begin
          if (x_q > y_q) x_d = diff_xy;
          else           y_d = diff_yx;
        end else begin
          if (!x_q[0] && !y_q[0]) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            k_d = k_q + 1'b1;
          end else if (!x_q[0]) begin
            x_d = x_q >> 1;
          end else if (!y_q[0]) begin
            y_d = y_q >> 1;
          end else if (x_q >= y_q) begin
            // Difference of two odd numbers is even; halve it right away.
            x_d = diff_xy >> 1;
          end else begin
            y_d = diff_yx >> 1;
          end
        end
      end

      DONE: begin
        if (io.io_out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign io.io_in_ready   = (state_q == IDLE);
  assign io.io_out_valid  = (state_q == DONE);
  assign io.io_busy       = (state_q == RUN) || (state_q == DONE);
  assign io.io_out_gcd    = res_q;
  assign io.io_out_cycles = cnt_q;
endmodule
